// File: rtl/fm_radio_pkg.sv
// Shared constants, state encoding and Q-format helpers for the FM receive chain.
package fm_radio_pkg;
    localparam int QUANT_BITS = 10;
    localparam int QUAD1      = 804;   // pi/4 in Q10
    localparam int QUAD3      = 2412;  // 3*pi/4 in Q10
    localparam int DEMOD_GAIN = 758;

    typedef enum logic [2:0] {
        S_IDLE, S_MULT, S_SETUP, S_DIV, S_SCALE, S_WRITE
    } fm_demod_state_t;

    function automatic logic signed [31:0] quantize(input logic signed [31:0] v);
        return v <<< QUANT_BITS;
    endfunction

    function automatic logic signed [31:0] dequantize(input logic signed [31:0] v);
        return v >>> QUANT_BITS;
    endfunction
endpackage

// File: rtl/div_iter.sv
// Signed restoring divider, one quotient bit per cycle, W iterations per division.
// Works on magnitudes and applies the sign at the output, so the quotient truncates toward zero.
module div_iter #(
    parameter int W = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    output logic signed [W-1:0] quotient,
    output logic                busy,
    output logic                done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d, busy_q, busy_d;
    logic [W:0]    rem_sh, trial;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        busy_d = busy_q;
        rem_sh = {rem_q, quo_q[W-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend[W-1] ? $unsigned(-dividend) : $unsigned(dividend);
            dvs_d  = divisor[W-1] ? $unsigned(-divisor) : $unsigned(divisor);
            neg_d  = dividend[W-1] ^ divisor[W-1];
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!trial[W]) begin
                rem_d = trial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            busy_q <= busy_d;
        end
    end

    // done flags the final iteration; the quotient register is settled the cycle after.
    assign done     = busy_q && (cnt_q == CW'(1));
    assign busy     = busy_q;
    assign quotient = neg_q ? -$signed(quo_q) : $signed(quo_q);
endmodule

// File: rtl/fm_demod.sv
// FM discriminator: angle(x[n]*conj(x[n-1])) via a divide-based arctan approximation, scaled by GAIN.
// Define FM_DEMOD_SAT_EN to clamp the output to [-32768, 32767]; otherwise the result wraps to 32 bits.
module fm_demod #(
    parameter int QUANT_BITS = 10,
    parameter int GAIN       = 758,
    parameter int DIV_W      = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] real_in,
    input  logic        real_empty,
    output logic        real_rd_en,
    input  logic [31:0] imag_in,
    input  logic        imag_empty,
    output logic        imag_rd_en,
    output logic [31:0] demod_out,
    output logic        out_wr_en,
    input  logic        out_full
);
    import fm_radio_pkg::*;

    fm_demod_state_t    state_q, state_d;
    logic signed [31:0] cr_q, cr_d, ci_q, ci_d, pr_q, pr_d, pi_q, pi_d;
    logic signed [31:0] r_q, r_d, i_q, i_d, res_q, res_d, demod_q, demod_d;
    logic               rd_q, rd_d, wr_q, wr_d;

    logic signed [63:0]      p_rr, p_ii, p_ir, p_ri;
    logic signed [31:0]      abs_y, num, den, res_c;
    logic signed [DIV_W-1:0] dividend, den_w, quotient, base_w, angle;
    logic                    div_start, div_busy, div_done;

    assign p_rr = 64'(cr_q) * 64'(pr_q);
    assign p_ii = 64'(ci_q) * 64'(pi_q);
    assign p_ir = 64'(ci_q) * 64'(pr_q);
    assign p_ri = 64'(cr_q) * 64'(pi_q);

    // The +1 keeps den strictly positive, so the divider never sees zero.
    always_comb begin
        abs_y = ((i_q < 0) ? -i_q : i_q) + 32'sd1;
        if (r_q >= 0) begin
            num = r_q - abs_y;
            den = r_q + abs_y;
        end else begin
            num = r_q + abs_y;
            den = abs_y - r_q;
        end
        dividend = DIV_W'(num) <<< QUANT_BITS;
        den_w    = DIV_W'(den);
    end

    always_comb begin
        base_w = (r_q < 0) ? DIV_W'(QUAD3) : DIV_W'(QUAD1);
        angle  = base_w - ((DIV_W'(QUAD1) * quotient) >>> QUANT_BITS);
        if (i_q < 0) angle = -angle;
    end

`ifdef FM_DEMOD_SAT_EN
    logic signed [DIV_W-1:0] res_w;
    always_comb begin
        res_w = (DIV_W'(GAIN) * angle) >>> QUANT_BITS;
        if (res_w > DIV_W'(32767))       res_c = 32'sd32767;
        else if (res_w < DIV_W'(-32768)) res_c = -32'sd32768;
        else                             res_c = 32'(res_w);
    end
`else
    assign res_c = 32'((DIV_W'(GAIN) * angle) >>> QUANT_BITS);
`endif

    div_iter #(.W(DIV_W)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (den_w),
        .quotient (quotient),
        .busy     (div_busy),
        .done     (div_done)
    );

    always_comb begin
        state_d   = state_q;
        cr_d      = cr_q;
        ci_d      = ci_q;
        pr_d      = pr_q;
        pi_d      = pi_q;
        r_d       = r_q;
        i_d       = i_q;
        res_d     = res_q;
        demod_d   = demod_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!real_empty && !imag_empty) begin
                    cr_d    = $signed(real_in);
                    ci_d    = $signed(imag_in);
                    rd_d    = 1'b1;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                r_d     = 32'((p_rr + p_ii) >>> QUANT_BITS);
                i_d     = 32'((p_ir - p_ri) >>> QUANT_BITS);
                pr_d    = cr_q;
                pi_d    = ci_q;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                div_start = 1'b1;
                state_d   = S_DIV;
            end
            S_DIV: begin
                if (div_done || !div_busy) state_d = S_SCALE;
            end
            S_SCALE: begin
                res_d   = res_c;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!out_full) begin
                    demod_d = res_q;
                    wr_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cr_q    <= '0;
            ci_q    <= '0;
            pr_q    <= '0;
            pi_q    <= '0;
            r_q     <= '0;
            i_q     <= '0;
            res_q   <= '0;
            demod_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            pr_q    <= pr_d;
            pi_q    <= pi_d;
            r_q     <= r_d;
            i_q     <= i_d;
            res_q   <= res_d;
            demod_q <= demod_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign real_rd_en = rd_q;
    assign imag_rd_en = rd_q;
    assign out_wr_en  = wr_q;
    assign demod_out  = demod_q;
endmodule

// File: tb/tb_fm_demod.sv
// Self-checking bench for fm_demod: FWFT FIFO models on both inputs, output capture,
// and an arithmetic reference model of the discriminator.
module tb_fm_demod;
    import fm_radio_pkg::*;

    localparam int Q     = 10;
    localparam int GAIN  = 758;
    localparam int DIV_W = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] real_in = '0, imag_in = '0;
    logic        real_empty = 1'b1, imag_empty = 1'b1, out_full = 1'b0;
    logic        real_rd_en, imag_rd_en, out_wr_en;
    logic [31:0] demod_out;

    int checks = 0, failures = 0;
    int cyc = 0;
    int rq[$], iq[$], outq[$], expq[$], pop_cyc[$], wr_cyc[$];
    int split_pops = 0, empty_pops = 0;
    int m_pr = 0, m_pi = 0;

    fm_demod #(.QUANT_BITS(Q), .GAIN(GAIN), .DIV_W(DIV_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .real_in    (real_in),
        .real_empty (real_empty),
        .real_rd_en (real_rd_en),
        .imag_in    (imag_in),
        .imag_empty (imag_empty),
        .imag_rd_en (imag_rd_en),
        .demod_out  (demod_out),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full)
    );

    always #5 clock = ~clock;

    // FIFO heads, pops and output capture, all on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (real_rd_en !== imag_rd_en) split_pops++;
        if (real_rd_en === 1'b1) begin
            if (rq.size() == 0) empty_pops++;
            else void'(rq.pop_front());
        end
        if (imag_rd_en === 1'b1) begin
            if (iq.size() == 0) empty_pops++;
            else void'(iq.pop_front());
        end
        if (real_rd_en === 1'b1 || imag_rd_en === 1'b1) pop_cyc.push_back(cyc);
        if (out_wr_en === 1'b1) begin
            outq.push_back(int'(demod_out));
            wr_cyc.push_back(cyc);
        end
        real_empty = (rq.size() == 0);
        imag_empty = (iq.size() == 0);
        real_in    = real_empty ? 32'd0 : rq[0];
        imag_in    = imag_empty ? 32'd0 : iq[0];
    end

    function automatic int model(int cr, int ci, int pr, int pi);
        longint r, i, ay, num, den, q, base, ang, res;
        r  = longint'(int'((longint'(cr) * pr + longint'(ci) * pi) >>> Q));
        i  = longint'(int'((longint'(ci) * pr - longint'(cr) * pi) >>> Q));
        ay = (i < 0 ? -i : i) + 1;
        if (r >= 0) begin num = r - ay; den = r + ay; base = 804; end
        else        begin num = r + ay; den = ay - r; base = 2412; end
        q   = (num * 1024) / den;
        ang = base - ((804 * q) >>> Q);
        if (i < 0) ang = -ang;
        res = (GAIN * ang) >>> Q;
`ifdef FM_DEMOD_SAT_EN
        if (res > 32767) res = 32767;
        else if (res < -32768) res = -32768;
`endif
        return int'(res);
    endfunction

    task automatic push(input int cr, input int ci);
        rq.push_back(cr);
        iq.push_back(ci);
        expq.push_back(model(cr, ci, m_pr, m_pi));
        m_pr = cr;
        m_pi = ci;
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        ok = (outq.size() >= n);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rq.delete(); iq.delete(); expq.delete();
        m_pr = 0; m_pi = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        outq.delete(); pop_cyc.delete(); wr_cyc.delete();
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        rq.push_back(1024); iq.push_back(0);
        repeat (4) @(negedge clock);
        checks++; if (demod_out !== 32'd0) begin failures++; $display("FAIL reset_demod_out got %0d expected 0", demod_out); end
        checks++; if (out_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b expected 0", out_wr_en); end
        checks++; if (real_rd_en !== 1'b0 || imag_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got %b%b expected 00", real_rd_en, imag_rd_en); end
        checks++; if (pop_cyc.size() != 0) begin failures++; $display("FAIL reset_pops got %0d expected 0", pop_cyc.size()); end
    endtask

    task automatic test_directed();
        int exp_c[8] = '{1190, 1, 1, 1190, -1191, -1191, 1190, 2379};
        int one = quantize(1);
        bit ok;
        do_reset();
        push(one, 0);  push(one, 0);
        push(one, 0);  push(0, one);
        push(one, 0);  push(0, -one);
        push(one, 0);  push(-one, 0);
        wait_out(8, 8 * (DIV_W + 5) + 100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL directed_timeout got %0d outputs expected 8", outq.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (outq[k] != exp_c[k]) begin failures++; $display("FAIL directed_out%0d got %0d expected %0d", k, outq[k], exp_c[k]); end
            end
            checks++;
            if (wr_cyc[0] - pop_cyc[0] != DIV_W + 4) begin failures++; $display("FAIL latency got %0d expected %0d", wr_cyc[0] - pop_cyc[0], DIV_W + 4); end
            checks++;
            if (pop_cyc[1] - pop_cyc[0] != DIV_W + 5) begin failures++; $display("FAIL throughput got %0d expected %0d", pop_cyc[1] - pop_cyc[0], DIV_W + 5); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        out_full = 1'b1;
        push(1024, 0);
        repeat (DIV_W + 10) @(negedge clock);
        push(0, 1024);
        repeat (50) @(negedge clock);
        checks++; if (outq.size() != 0) begin failures++; $display("FAIL full_no_write got %0d writes expected 0", outq.size()); end
        checks++; if (pop_cyc.size() != 1) begin failures++; $display("FAIL full_no_pop got %0d pops expected 1", pop_cyc.size()); end
        checks++; if (demod_out !== 32'd0) begin failures++; $display("FAIL full_hold got %0d expected 0", demod_out); end
        out_full = 1'b0;
        wait_out(2, 2 * (DIV_W + 5) + 50, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL full_release_timeout got %0d outputs expected 2", outq.size());
        end else begin
            checks++; if (outq[0] != 1190) begin failures++; $display("FAIL full_pending got %0d expected 1190", outq[0]); end
            checks++; if (outq[1] != 1190) begin failures++; $display("FAIL full_next got %0d expected 1190", outq[1]); end
            checks++; if (pop_cyc[1] - wr_cyc[0] != 1) begin failures++; $display("FAIL full_pop_after_write got %0d expected 1", pop_cyc[1] - wr_cyc[0]); end
            checks++; if (wr_cyc[1] - wr_cyc[0] != DIV_W + 5) begin failures++; $display("FAIL full_single_write got %0d expected %0d", wr_cyc[1] - wr_cyc[0], DIV_W + 5); end
        end
    endtask

    task automatic test_one_sided();
        int exp_v;
        bit ok;
        do_reset();
        rq.push_back(2048);
        repeat (20) @(negedge clock);
        checks++; if (pop_cyc.size() != 0) begin failures++; $display("FAIL one_sided_pop got %0d pops expected 0", pop_cyc.size()); end
        exp_v = model(2048, -512, 0, 0);
        iq.push_back(-512);
        wait_out(1, DIV_W + 40, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL one_sided_timeout got %0d outputs expected 1", outq.size());
        end else begin
            checks++; if (outq[0] != exp_v) begin failures++; $display("FAIL one_sided_out got %0d expected %0d", outq[0], exp_v); end
            checks++; if (pop_cyc.size() != 1 || rq.size() != 0 || iq.size() != 0) begin failures++; $display("FAIL one_sided_single_pop got %0d pops expected 1", pop_cyc.size()); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        do_reset();
        push(2048, 100);
        wait_out(1, DIV_W + 40, ok);
        push(1000, 300);
        while (pop_cyc.size() < 2 && k < 300) begin @(negedge clock); k++; end
        checks++; if (pop_cyc.size() < 2) begin failures++; $display("FAIL mid_pop_timeout got %0d pops expected 2", pop_cyc.size()); end
        repeat (10) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (DIV_W + 20) @(negedge clock);
        checks++; if (outq.size() != 1) begin failures++; $display("FAIL mid_no_write got %0d writes expected 1", outq.size()); end
        outq.delete(); expq.delete();
        m_pr = 0; m_pi = 0;
        push(1024, 0);
        wait_out(1, DIV_W + 40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_after_timeout got %0d outputs expected 1", outq.size()); end
        else if (outq[0] != 1190) begin failures++; $display("FAIL mid_history_cleared got %0d expected 1190", outq[0]); end
    endtask

    task automatic test_random();
        localparam int N = 24;
        int k = 0;
        do_reset();
        for (int n = 0; n < N; n++) begin
            int amp = ($urandom_range(0, 1) == 0) ? 2048 : 65536;
            push(int'($urandom_range(0, 2 * amp)) - amp, int'($urandom_range(0, 2 * amp)) - amp);
        end
        while (outq.size() < N && k < N * (DIV_W + 5) * 2) begin
            out_full = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            k++;
        end
        out_full = 1'b0;
        checks++;
        if (outq.size() != N) begin
            failures++; $display("FAIL random_count got %0d expected %0d", outq.size(), N);
        end else begin
            for (int j = 0; j < N; j++) begin
                checks++;
                if (outq[j] != expq[j]) begin failures++; $display("FAIL random_out%0d got %0d expected %0d", j, outq[j], expq[j]); end
            end
        end
        checks++; if (split_pops != 0) begin failures++; $display("FAIL split_pops got %0d expected 0", split_pops); end
        checks++; if (empty_pops != 0) begin failures++; $display("FAIL empty_pops got %0d expected 0", empty_pops); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_one_sided();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
